mdio_arbiter: RTL and testbench
===============================

// Module: mdio_arbiter
// PURPOSE
//  Shares one mdio_master between N_REQ requesters (PHY init, link poller, CPU regs).
//  Round-robin grant; each transaction is one MDIO read or write.
//  Drives mdio_master command inputs and single-cycle start, tracks busy, returns read data.
//  Adds a watchdog so a hung master can never lock out requesters.
// PARAMETERS
//  N_REQ        4    number of requesters (>=2)
//  BUSY_WAIT    4    cycles after mst_start allowed for mst_busy to rise
//  TIMEOUT_CYC  256  max cycles mst_busy may stay high before abort
// PORTS
//  clk           in   1         MDC-domain clock (2.5 MHz)
//  rst           in   1         asynchronous reset, active-high
//  req_valid     in   N_REQ     per-requester command valid, held until req_ready
//  req_ready     out  N_REQ     one-hot accept pulse (1 cycle)
//  req_write     in   N_REQ     1=write, 0=read
//  req_phy_addr  in   N_REQ*5   packed, requester i at [5i+:5]
//  req_reg_addr  in   N_REQ*5   packed, requester i at [5i+:5]
//  req_wdata     in   N_REQ*16  packed, requester i at [16i+:16]
//  rsp_valid     out  N_REQ     one-hot completion pulse to owning requester
//  rsp_rdata     out  16        read data (0 for writes), valid with rsp_valid
//  rsp_err       out  1         timeout flag, valid with rsp_valid
//  grant_id      out  $clog2(N_REQ)  current/last owner
//  mst_phy_addr  out  5         to mdio_master.phy_addr
//  mst_reg_addr  out  5         to mdio_master.reg_addr
//  mst_data_in   out  16        to mdio_master.data_in
//  mst_write_en  out  1         to mdio_master.write_en
//  mst_start     out  1         to mdio_master.start, single-cycle pulse
//  mst_busy      in   1         from mdio_master.busy
//  mst_rdata     in   16        read data from master, sampled on busy falling edge
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0; async assert, sync release.
//  Reset mid-transaction: abandon immediately, no rsp_valid; master resets separately.
//  FSM: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> RESP -> IDLE.
//  IDLE: if any req_valid, pick first asserted index at/after rr pointer (wrapping);
//    req_ready[g]=1 that cycle; latch command into mst_* regs; grant_id=g;
//    rr pointer = (g+1) mod N_REQ. No requests -> stay IDLE, pointer unchanged.
//  ISSUE: mst_start=1 for exactly one cycle (accept cycle T -> start at T+1).
//  WAIT_BUSY: wait mst_busy=1; if absent after BUSY_WAIT cycles -> RESP, rsp_err=1.
//  WAIT_DONE: count cycles; mst_busy=0 -> capture mst_rdata (reads only) -> RESP;
//    count reaches TIMEOUT_CYC -> RESP with rsp_err=1, rsp_rdata=0.
//  RESP: rsp_valid[g]=1, rsp_err, rsp_rdata for one cycle; then IDLE.
//  mst_phy_addr/reg_addr/data_in/write_en held stable ISSUE..RESP; unchanged in IDLE.
//  No new grant while not IDLE; at most one accept per transaction (no back-to-back).
//  req_valid dropped before grant: legal, simply not considered.
//  Simultaneous requests: strict rotation, every requester served within N_REQ grants.
//  Counters saturate at limits; no wrap.
// STRUCTURE
//  Package mdio_arb_pkg: state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP),
//    MDIO_ADDR_W=5, MDIO_DATA_W=16.
//  Sub-module mdio_rr_arbiter: N_REQ-wide round-robin grant (req, ptr -> one-hot, idx).
//  Top holds FSM, command/response regs, watchdog counter.
// TESTING
//  Single write: req0 write phy=5 reg=10 wdata=AAAA -> ready0 at T, start at T+1,
//    mst_* = 5/10/AAAA/1 stable until rsp_valid0, rsp_err=0, rsp_rdata=0.
//  Read: req2 read phy=1 reg=2, master model returns 1234 -> rsp_valid2, rsp_rdata=1234.
//  Contention: req0..3 all valid continuously -> grant order 0,1,2,3,0; ptr wraps.
//  Dead master: mst_busy never rises -> rsp_err=1 after BUSY_WAIT; next req served.
//  Stuck busy: busy held high -> rsp_err=1 after TIMEOUT_CYC, FSM back to IDLE.
//  Reset in WAIT_DONE: rst pulse -> all outputs 0 immediately, no rsp_valid, ptr=0.

Source files
------------

// File: rtl/mdio_arb_pkg.sv
// Shared types and widths for the MDIO requester arbiter.
package mdio_arb_pkg;

   localparam int unsigned MDIO_ADDR_W = 5;
   localparam int unsigned MDIO_DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE,
      RESP
   } arb_state_t;

   typedef struct packed {
      logic                   write;
      logic [MDIO_ADDR_W-1:0] phy_addr;
      logic [MDIO_ADDR_W-1:0] reg_addr;
      logic [MDIO_DATA_W-1:0] wdata;
   } mdio_cmd_t;

endpackage

// File: rtl/mdio_rr_arbiter.sv
// Round-robin pick: first asserted request at or after the pointer, wrapping.
module mdio_rr_arbiter #(
   parameter  int unsigned N_REQ = 4,
   localparam int unsigned IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_gnt_c,
   output logic [IDX_W-1:0] o_idx_c,
   output logic             o_any_c
);

   function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                 input int unsigned      off);
      int unsigned sum;
      sum = 32'(base) + off;
      if (sum >= N_REQ) sum = sum - N_REQ;
      return IDX_W'(sum);
   endfunction

   always_comb begin
      o_gnt_c = '0;
      o_idx_c = '0;
      o_any_c = 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (!o_any_c && i_req[wrap_idx(i_ptr, k)]) begin
            o_any_c                      = 1'b1;
            o_idx_c                      = wrap_idx(i_ptr, k);
            o_gnt_c[wrap_idx(i_ptr, k)]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mdio_arbiter.sv
// Shares one mdio_master between N_REQ requesters with round-robin grant
// and a watchdog on the master's busy handshake.
module mdio_arbiter
   import mdio_arb_pkg::*;
#(
   parameter  int unsigned N_REQ       = 4,
   parameter  int unsigned BUSY_WAIT   = 4,
   parameter  int unsigned TIMEOUT_CYC = 256,
   localparam int unsigned ID_W        = $clog2(N_REQ)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N_REQ-1:0]               req_valid,
   output logic [N_REQ-1:0]               req_ready,
   input  logic [N_REQ-1:0]               req_write,
   input  logic [N_REQ*MDIO_ADDR_W-1:0]   req_phy_addr,
   input  logic [N_REQ*MDIO_ADDR_W-1:0]   req_reg_addr,
   input  logic [N_REQ*MDIO_DATA_W-1:0]   req_wdata,
   output logic [N_REQ-1:0]               rsp_valid,
   output logic [MDIO_DATA_W-1:0]         rsp_rdata,
   output logic                           rsp_err,
   output logic [ID_W-1:0]                grant_id,
   output logic [MDIO_ADDR_W-1:0]         mst_phy_addr,
   output logic [MDIO_ADDR_W-1:0]         mst_reg_addr,
   output logic [MDIO_DATA_W-1:0]         mst_data_in,
   output logic                           mst_write_en,
   output logic                           mst_start,
   input  logic                           mst_busy,
   input  logic [MDIO_DATA_W-1:0]         mst_rdata
);

   localparam int unsigned CNT_MAX = (TIMEOUT_CYC > BUSY_WAIT) ? TIMEOUT_CYC : BUSY_WAIT;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] BUSY_LIM    = CNT_W'(BUSY_WAIT - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC - 1);

   arb_state_t             r_state, w_state_nxt;
   logic [ID_W-1:0]        r_ptr, w_ptr_nxt;
   logic [ID_W-1:0]        r_grant, w_grant_nxt;
   logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
   mdio_cmd_t              r_cmd, w_cmd_nxt;
   logic [N_REQ-1:0]       r_ready, w_ready_nxt;
   logic [N_REQ-1:0]       r_rsp_valid, w_rsp_valid_nxt;
   logic                   r_start, w_start_nxt;
   logic                   r_rsp_err, w_rsp_err_nxt;
   logic [MDIO_DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;

   logic [N_REQ-1:0]       w_gnt;
   logic [ID_W-1:0]        w_idx;
   logic                   w_any;
   mdio_cmd_t              w_req_cmd;
   logic [N_REQ-1:0]       w_owner_1h;

   mdio_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .o_gnt_c (w_gnt),
      .o_idx_c (w_idx),
      .o_any_c (w_any)
   );

   // Select the winning requester's command fields from the packed buses.
   always_comb begin
      w_req_cmd = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (w_idx == ID_W'(k)) begin
            w_req_cmd.write    = req_write[k];
            w_req_cmd.phy_addr = req_phy_addr[k*MDIO_ADDR_W +: MDIO_ADDR_W];
            w_req_cmd.reg_addr = req_reg_addr[k*MDIO_ADDR_W +: MDIO_ADDR_W];
            w_req_cmd.wdata    = req_wdata[k*MDIO_DATA_W +: MDIO_DATA_W];
         end
      end
   end

   assign w_owner_1h = N_REQ'(1) << r_grant;

   // Next state and next values of every registered output.
   always_comb begin
      w_state_nxt     = r_state;
      w_ptr_nxt       = r_ptr;
      w_grant_nxt     = r_grant;
      w_cnt_nxt       = r_cnt;
      w_cmd_nxt       = r_cmd;
      w_ready_nxt     = '0;
      w_start_nxt     = 1'b0;
      w_rsp_valid_nxt = '0;
      w_rsp_err_nxt   = 1'b0;
      w_rsp_rdata_nxt = '0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_nxt = ISSUE;
               w_ready_nxt = w_gnt;
               w_grant_nxt = w_idx;
               w_cmd_nxt   = w_req_cmd;
               w_ptr_nxt   = (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + ID_W'(1);
            end
         end
         ISSUE: begin
            w_state_nxt = WAIT_BUSY;
            w_start_nxt = 1'b1;
            w_cnt_nxt   = '0;
         end
         WAIT_BUSY: begin
            if (mst_busy) begin
               w_state_nxt = WAIT_DONE;
               w_cnt_nxt   = '0;
            end else if (r_cnt >= BUSY_LIM) begin
               w_state_nxt     = RESP;
               w_rsp_valid_nxt = w_owner_1h;
               w_rsp_err_nxt   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         WAIT_DONE: begin
            // Falling busy marks completion; read data is valid on that edge.
            if (!mst_busy) begin
               w_state_nxt     = RESP;
               w_rsp_valid_nxt = w_owner_1h;
               w_rsp_rdata_nxt = r_cmd.write ? '0 : mst_rdata;
            end else if (r_cnt >= TIMEOUT_LIM) begin
               w_state_nxt     = RESP;
               w_rsp_valid_nxt = w_owner_1h;
               w_rsp_err_nxt   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_grant     <= '0;
         r_cnt       <= '0;
         r_cmd       <= '0;
         r_ready     <= '0;
         r_start     <= 1'b0;
         r_rsp_valid <= '0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_ptr       <= w_ptr_nxt;
         r_grant     <= w_grant_nxt;
         r_cnt       <= w_cnt_nxt;
         r_cmd       <= w_cmd_nxt;
         r_ready     <= w_ready_nxt;
         r_start     <= w_start_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
      end
   end

   assign req_ready    = r_ready;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_rdata    = r_rsp_rdata;
   assign rsp_err      = r_rsp_err;
   assign grant_id     = r_grant;
   assign mst_phy_addr = r_cmd.phy_addr;
   assign mst_reg_addr = r_cmd.reg_addr;
   assign mst_data_in  = r_cmd.wdata;
   assign mst_write_en = r_cmd.write;
   assign mst_start    = r_start;

endmodule

// File: tb/tb_mdio_arbiter.sv
// Randomised scoreboard bench for mdio_arbiter with a behavioural mdio_master model.
module tb_mdio_arbiter;
   import mdio_arb_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned BW = 4;
   localparam int unsigned TO = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
   logic [N*5-1:0]  req_phy_addr, req_reg_addr;
   logic [N*16-1:0] req_wdata;
   logic [15:0]     rsp_rdata;
   logic            rsp_err;
   logic [1:0]      grant_id;
   logic [4:0]      mst_phy_addr, mst_reg_addr;
   logic [15:0]     mst_data_in;
   logic            mst_write_en, mst_start, mst_busy;
   logic [15:0]     mst_rdata;

   logic        tb_valid [N];
   logic        tb_write [N];
   logic [4:0]  tb_phy   [N];
   logic [4:0]  tb_reg   [N];
   logic [15:0] tb_wdata [N];

   for (genvar k = 0; k < N; k++) begin : g_pack
      assign req_valid[k]           = tb_valid[k];
      assign req_write[k]           = tb_write[k];
      assign req_phy_addr[k*5 +: 5] = tb_phy[k];
      assign req_reg_addr[k*5 +: 5] = tb_reg[k];
      assign req_wdata[k*16 +: 16]  = tb_wdata[k];
   end

   mdio_arbiter #(.N_REQ(N), .BUSY_WAIT(BW), .TIMEOUT_CYC(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_phy_addr (req_phy_addr),
      .req_reg_addr (req_reg_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .grant_id     (grant_id),
      .mst_phy_addr (mst_phy_addr),
      .mst_reg_addr (mst_reg_addr),
      .mst_data_in  (mst_data_in),
      .mst_write_en (mst_write_en),
      .mst_start    (mst_start),
      .mst_busy     (mst_busy),
      .mst_rdata    (mst_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      int          lat;   // cycles from accept to response; 0 = not checked
   } exp_t;

   exp_t exp_q [N][$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   mst_mode = 0;    // 0 normal, 1 dead (no busy), 2 stuck busy

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic fail(input string name);
      n_checks++;
      $display("FAIL %s: expected event did not occur", name);
   endtask

   function automatic logic [15:0] model_rdata(input logic [4:0] p, input logic [4:0] r);
      return {p, r, 6'h15} ^ 16'h5A3C;
   endfunction

   function automatic exp_t norm_exp(input logic w, input logic [4:0] p, input logic [4:0] r);
      exp_t e;
      e.rdata = w ? 16'h0 : model_rdata(p, r);
      e.err   = 1'b0;
      e.lat   = 0;
      return e;
   endfunction

   // Rotation rule: first valid requester at or after the pointer.
   function automatic int rr_pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++)
         if (v[(p + k) % N]) return int'((p + k) % N);
      return -1;
   endfunction

   function automatic int q_total();
      int s = 0;
      for (int k = 0; k < N; k++) s += exp_q[k].size();
      return s;
   endfunction

   // Behavioural mdio_master.
   logic [4:0] m_p, m_r;
   logic       m_w;
   int         m_len;
   initial begin
      mst_busy  = 1'b0;
      mst_rdata = 16'h0;
      forever begin
         @(negedge clk);
         if (mst_start && !rst) begin
            if (mst_mode == 0) begin
               m_p = mst_phy_addr; m_r = mst_reg_addr; m_w = mst_write_en;
               m_len = $urandom_range(1, 6);
               @(posedge clk); #1;
               mst_busy  = 1'b1;
               mst_rdata = 16'($urandom);
               repeat (m_len) @(posedge clk);
               #1;
               mst_rdata = m_w ? 16'($urandom) : model_rdata(m_p, m_r);
               mst_busy  = 1'b0;
            end else if (mst_mode == 2) begin
               @(posedge clk); #1;
               mst_busy = 1'b1;
               while (mst_mode == 2 && !rst) @(posedge clk);
               #1;
               mst_busy = 1'b0;
            end
         end
      end
   end

   // Monitor: grant order, start timing, command integrity, response scoreboard.
   int          cyc = 0, m_ptr = 0, cur_g = 0, ready_cyc = 0, g = 0;
   bit          start_due = 1'b0;
   logic [N-1:0] prev_v = '0;
   logic [26:0] c_cmd = '0;
   exp_t        m_e;
   always @(negedge clk) begin
      if (rst) begin
         m_ptr     = 0;
         start_due = 1'b0;
         prev_v    = '0;
      end else begin
         cyc++;
         if (req_ready != '0) begin
            g = 0;
            for (int k = N - 1; k >= 0; k--) if (req_ready[k]) g = k;
            check("ready_onehot", 64'($countones(req_ready)), 64'd1);
            check("grant_order", 64'(g), 64'(rr_pick(prev_v, m_ptr)));
            check("grant_id", 64'(grant_id), 64'(g));
            m_ptr     = int'((g + 1) % N);
            cur_g     = g;
            ready_cyc = cyc;
            start_due = 1'b1;
            c_cmd     = {tb_write[g], tb_phy[g], tb_reg[g], tb_wdata[g]};
         end
         if (mst_start) begin
            if (!start_due) fail("start_unexpected");
            else begin
               check("start_timing", 64'(cyc - ready_cyc), 64'd1);
               check("start_cmd", {mst_write_en, mst_phy_addr, mst_reg_addr, mst_data_in}, c_cmd);
            end
            start_due = 1'b0;
         end
         if (rsp_valid != '0) begin
            check("rsp_owner", 64'(rsp_valid), 64'(1) << cur_g);
            if (exp_q[cur_g].size() == 0) fail("rsp_unexpected");
            else begin
               m_e = exp_q[cur_g].pop_front();
               check("rsp_rdata", 64'(rsp_rdata), 64'(m_e.rdata));
               check("rsp_err", 64'(rsp_err), 64'(m_e.err));
               if (m_e.lat > 0) check("rsp_latency", 64'(cyc - ready_cyc), 64'(m_e.lat));
               check("cmd_stable", {mst_write_en, mst_phy_addr, mst_reg_addr, mst_data_in}, c_cmd);
            end
         end
         prev_v = req_valid;
      end
   end

   task automatic do_req(input int i, input logic w, input logic [4:0] p,
                         input logic [4:0] r, input logic [15:0] d, input exp_t e);
      bit got = 1'b0;
      @(posedge clk); #1;
      tb_write[i] = w; tb_phy[i] = p; tb_reg[i] = r; tb_wdata[i] = d;
      exp_q[i].push_back(e);
      tb_valid[i] = 1'b1;
      for (int n = 0; n < 4000 && !got; n++) begin
         @(negedge clk);
         if (req_ready[i]) got = 1'b1;
      end
      if (!got) fail("ready_timeout");
      @(posedge clk); #1;
      tb_valid[i] = 1'b0;
   endtask

   task automatic rand_client(input int i, input int n);
      logic w; logic [4:0] p, r; logic [15:0] d;
      for (int t = 0; t < n; t++) begin
         w = 1'($urandom); p = 5'($urandom); r = 5'($urandom); d = 16'($urandom);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         do_req(i, w, p, r, d, norm_exp(w, p, r));
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while (q_total() != 0 && n < 3000) begin @(negedge clk); n++; end
      if (q_total() != 0) fail("rsp_timeout");
      repeat (2) @(negedge clk);
   endtask

   exp_t e_err;
   int   n_wait;
   initial begin
      for (int k = 0; k < N; k++) begin
         tb_valid[k] = 1'b0; tb_write[k] = 1'b0; tb_phy[k] = '0; tb_reg[k] = '0; tb_wdata[k] = '0;
      end
      repeat (3) @(posedge clk); #1;
      check("reset_outputs", {req_ready, rsp_valid, rsp_rdata, rsp_err, grant_id, mst_phy_addr,
                              mst_reg_addr, mst_data_in, mst_write_en, mst_start}, 64'd0);
      rst = 1'b0;

      do_req(0, 1'b1, 5'd5, 5'd10, 16'hAAAA, norm_exp(1'b1, 5'd5, 5'd10));
      wait_drain();
      do_req(2, 1'b0, 5'd1, 5'd2, 16'h0, norm_exp(1'b0, 5'd1, 5'd2));
      wait_drain();

      // All four contend at once, requester 0 comes back for a second turn.
      fork
         begin
            do_req(0, 1'b0, 5'd3, 5'd4, 16'h0, norm_exp(1'b0, 5'd3, 5'd4));
            do_req(0, 1'b1, 5'd6, 5'd7, 16'h1111, norm_exp(1'b1, 5'd6, 5'd7));
         end
         do_req(1, 1'b0, 5'd8, 5'd9, 16'h0, norm_exp(1'b0, 5'd8, 5'd9));
         do_req(2, 1'b1, 5'd10, 5'd11, 16'h2222, norm_exp(1'b1, 5'd10, 5'd11));
         do_req(3, 1'b0, 5'd12, 5'd13, 16'h0, norm_exp(1'b0, 5'd12, 5'd13));
      join
      wait_drain();

      fork
         rand_client(0, 10);
         rand_client(1, 10);
         rand_client(2, 10);
         rand_client(3, 10);
      join
      wait_drain();

      // Dead master: busy never rises.
      mst_mode = 1;
      e_err = '{rdata: 16'h0, err: 1'b1, lat: int'(BW + 1)};
      do_req(1, 1'b0, 5'd3, 5'd4, 16'h0, e_err);
      wait_drain();
      mst_mode = 0;
      do_req(2, 1'b0, 5'd9, 5'd1, 16'h0, norm_exp(1'b0, 5'd9, 5'd1));
      wait_drain();

      // Stuck master: busy never falls.
      mst_mode = 2;
      e_err = '{rdata: 16'h0, err: 1'b1, lat: int'(TO + 3)};
      do_req(3, 1'b0, 5'd7, 5'd8, 16'h0, e_err);
      wait_drain();
      mst_mode = 0;
      repeat (3) @(posedge clk);
      do_req(0, 1'b0, 5'd2, 5'd30, 16'h0, norm_exp(1'b0, 5'd2, 5'd30));
      wait_drain();

      // Reset while waiting for the master to finish.
      mst_mode = 2;
      do_req(1, 1'b1, 5'd9, 5'd9, 16'h1234, norm_exp(1'b1, 5'd9, 5'd9));
      n_wait = 0;
      while (!mst_busy && n_wait < 100) begin @(negedge clk); n_wait++; end
      if (!mst_busy) fail("busy_timeout");
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check("reset_async_outputs", {req_ready, rsp_valid, rsp_rdata, rsp_err, grant_id, mst_phy_addr,
                                    mst_reg_addr, mst_data_in, mst_write_en, mst_start}, 64'd0);
      for (int k = 0; k < N; k++) exp_q[k].delete();
      mst_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Pointer back at 0: requester 1 must beat requester 3.
      fork
         do_req(3, 1'b0, 5'd17, 5'd18, 16'h0, norm_exp(1'b0, 5'd17, 5'd18));
         do_req(1, 1'b1, 5'd19, 5'd20, 16'hBEEF, norm_exp(1'b1, 5'd19, 5'd20));
      join
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
